qarma128_tweak_sched: RTL and testbench
=======================================

Name: qarma128_tweak_sched

Overview:
Sequential tweak schedule for the QARMA-128 datapath; sits directly upstream of the round function and feeds it one round tweak per handshake.
- Accepts a 128-bit tweak.
- Forward pass: emits T_0..T_{ROUNDS-1}, stepping T <- LFSR(h(T)).
- Backward pass: emits T_{ROUNDS-1}..T_0, stepping T <- h_inv(InvLFSR(T)).
- Reuses the existing LFSR / InvLFSR modules for the cell-wise update.

Parameters:
ROUNDS, 8, forward round count; legal 2..15; backward count is equal, so each job emits 2*ROUNDS tweaks.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  new tweak offered
in_ready  out  1  block can accept a new tweak
in_tweak  in  128  tweak; cell 0 = bits [127:120], cell 15 = bits [7:0]
out_valid  out  1  out_tweak valid
out_ready  in  1  consumer accepts out_tweak
out_tweak  out  128  current round tweak
out_round  out  4  round index of out_tweak
out_dir  out  1  0 = forward pass, 1 = backward pass
out_last  out  1  high with the final tweak of a job

Behaviour:
- Cell operations:
  - Cells are 8 bits wide.
  - h: out cell i = in cell H[i], with H = [6,5,14,15,0,1,2,3,7,12,13,4,8,9,10,11].
  - h_inv uses HI = [4,5,6,7,11,1,0,8,12,13,14,15,9,10,2,3].
  - LFSR touches only cells {0,1,3,4,8,11,13} (mask 16'h291B); each such cell x -> {x[0]^x[2], x[7:1]}. InvLFSR is the exact inverse.
- FSM states IDLE, FWD, BWD. Registers: tweak_q (128), round_q (4), state.
- Reset: state = IDLE, tweak_q = 0, round_q = 0. Reset takes priority over everything; mid-job it abandons the job with no further outputs.
- Output reset values: out_valid = 0, out_tweak = 0, out_round = 0, out_dir = 0, out_last = 0, in_ready = 1.
- in_ready = (state == IDLE). out_valid = (state != IDLE). out_tweak = tweak_q. out_round = round_q. out_dir = (state == BWD).
- out_last = (state == BWD) && (round_q == 0).
- IDLE: on in_valid, load tweak_q <= in_tweak, round_q <= 0, go to FWD. First out_valid appears the cycle after acceptance (latency 1).
- FWD, on fire (out_valid & out_ready):
  - If round_q == ROUNDS-1: go to BWD; tweak_q and round_q hold, so T_{ROUNDS-1} is emitted again as the first backward tweak.
  - Else: tweak_q <= LFSR(h(tweak_q)), round_q++.
- BWD, on fire:
  - If round_q == 0: go to IDLE.
  - Else: tweak_q <= h_inv(InvLFSR(tweak_q)), round_q--.
- No fire: all registers hold, and out_tweak, out_round and out_dir stay stable (backpressure).
- No accept in the same cycle as the last fire; in_ready rises the cycle after out_last fires. in_valid outside IDLE is ignored.
- Throughput: one tweak per cycle while out_ready is high. A job takes 2*ROUNDS cycles plus 1 for acceptance.

Decomposition:
- qarma128_pkg holds: CELL_W = 8, N_CELLS = 16, H_PERM, H_INV_PERM, LFSR_CELL_MASK = 16'h291B, and state typedef {IDLE, FWD, BWD}.
- Natural sub-module: qarma128_tweak_perm, a combinational h / h_inv selected by a direction input. The FSM and registers stay in qarma128_tweak_sched, which instantiates LFSR and InvLFSR.

Test Plan:
- in_tweak = 0, out_ready = 1 -> 16 outputs, all 0; out_round sequence 0..7 then 7..0; out_last only on the 16th output.
- in_tweak = 128'h01 << 120 (cell 0 = 0x01) -> second output = 128'h0000_0000_8000_0000_0000_0000_0000_0000 (cell 4 = 0x80), out_round = 1.
- Random tweak, ROUNDS = 8 -> backward output k equals forward output 7-k for all k; final output equals in_tweak.
- Hold out_ready low 3 cycles at round 3 -> out_valid = 1 and out_tweak / out_round unchanged throughout; sequence resumes unchanged.
- Assert rst at forward round 5 -> next cycle out_valid = 0, in_ready = 1, out_tweak = 0; a new job then runs normally from round 0.
- in_valid held high continuously -> in_ready = 0 during the job; the next tweak is accepted exactly one cycle after the out_last fire.

Source files
------------

// File: rtl/qarma128_pkg.sv
// Shared constants and types for the QARMA-128 tweak path.
// Cell 0 is the most significant byte of a 128-bit tweak.
package qarma128_pkg;

  localparam int CELL_W  = 8;
  localparam int N_CELLS = 16;
  localparam int TWEAK_W = CELL_W * N_CELLS;

  // Element 0 is the leftmost entry, so H_PERM[i] is the source cell of output cell i.
  localparam logic [0:N_CELLS-1][3:0] H_PERM = {
    4'd6, 4'd5, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3,
    4'd7, 4'd12, 4'd13, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11
  };

  localparam logic [0:N_CELLS-1][3:0] H_INV_PERM = {
    4'd4, 4'd5, 4'd6, 4'd7, 4'd11, 4'd1, 4'd0, 4'd8,
    4'd12, 4'd13, 4'd14, 4'd15, 4'd9, 4'd10, 4'd2, 4'd3
  };

  // Bit i set means cell i passes through the LFSR.
  localparam logic [N_CELLS-1:0] LFSR_CELL_MASK = 16'h291B;

  typedef logic [0:N_CELLS-1][CELL_W-1:0] cells_t;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    BWD
  } sched_state_t;

endpackage

// File: rtl/qarma128_lfsr.sv
// Cell-wise LFSR and its inverse over the masked tweak cells.
// Combinational, no backpressure.
module qarma128_lfsr
  import qarma128_pkg::*;
(
  input  logic [TWEAK_W-1:0] tweak,
  output logic [TWEAK_W-1:0] result
);

  cells_t c_in;
  cells_t c_out;

  assign c_in   = tweak;
  assign result = c_out;

  for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
    if (LFSR_CELL_MASK[i]) begin : g_step
      assign c_out[i] = {c_in[i][0] ^ c_in[i][2], c_in[i][7:1]};
    end else begin : g_pass
      assign c_out[i] = c_in[i];
    end
  end

endmodule

module qarma128_inv_lfsr
  import qarma128_pkg::*;
(
  input  logic [TWEAK_W-1:0] tweak,
  output logic [TWEAK_W-1:0] result
);

  cells_t c_in;
  cells_t c_out;

  assign c_in   = tweak;
  assign result = c_out;

  // Old bit 0 is recovered from the feedback bit and old bit 2 (now bit 1).
  for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
    if (LFSR_CELL_MASK[i]) begin : g_step
      assign c_out[i] = {c_in[i][6:0], c_in[i][7] ^ c_in[i][1]};
    end else begin : g_pass
      assign c_out[i] = c_in[i];
    end
  end

endmodule

// File: rtl/qarma128_tweak_perm.sv
// Cell permutation h (inv = 0) or h_inv (inv = 1).
// Combinational, no backpressure.
module qarma128_tweak_perm
  import qarma128_pkg::*;
(
  input  logic               inv,
  input  logic [TWEAK_W-1:0] tweak,
  output logic [TWEAK_W-1:0] permuted
);

  cells_t c_in;
  cells_t c_out;

  assign c_in     = tweak;
  assign permuted = c_out;

  for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
    logic [3:0] src;
    assign src      = inv ? H_INV_PERM[i] : H_PERM[i];
    assign c_out[i] = c_in[src];
  end

endmodule

// File: rtl/qarma128_tweak_sched.sv
// Emits T_0..T_{R-1} then T_{R-1}..T_0 for each accepted tweak; first output 1 cycle after accept.
// Valid/ready on both sides; a stalled output holds every register, in_ready only while idle.
module qarma128_tweak_sched
  import qarma128_pkg::*;
#(
  parameter int ROUNDS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_tweak,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_tweak,
  output logic [3:0]   out_round,
  output logic         out_dir,
  output logic         out_last
);

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  sched_state_t state_q, state_d;
  logic [127:0] tweak_q, tweak_d;
  logic [3:0]   round_q, round_d;

  logic [127:0] inv_lfsr_out;
  logic [127:0] perm_in;
  logic [127:0] perm_out;
  logic [127:0] lfsr_out;
  logic         is_bwd;
  logic         fire;

  assign is_bwd = (state_q == BWD);
  assign fire   = out_valid & out_ready;

  // One shared permutation: h(T) feeds the LFSR going forward,
  // h_inv(InvLFSR(T)) is the step itself going backward.
  assign perm_in = is_bwd ? inv_lfsr_out : tweak_q;

  qarma128_inv_lfsr u_inv_lfsr (
    .tweak  (tweak_q),
    .result (inv_lfsr_out)
  );

  qarma128_tweak_perm u_perm (
    .inv      (is_bwd),
    .tweak    (perm_in),
    .permuted (perm_out)
  );

  qarma128_lfsr u_lfsr (
    .tweak  (perm_out),
    .result (lfsr_out)
  );

  always_comb begin
    state_d = state_q;
    tweak_d = tweak_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          tweak_d = in_tweak;
          round_d = 4'd0;
          state_d = FWD;
        end
      end
      FWD: begin
        if (fire) begin
          if (round_q == LAST_RND) begin
            state_d = BWD;
          end else begin
            tweak_d = lfsr_out;
            round_d = round_q + 4'd1;
          end
        end
      end
      BWD: begin
        if (fire) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            tweak_d = perm_out;
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tweak_q <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      tweak_q <= tweak_d;
      round_q <= round_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q != IDLE);
  assign out_tweak = tweak_q;
  assign out_round = round_q;
  assign out_dir   = is_bwd;
  assign out_last  = is_bwd && (round_q == 4'd0);

endmodule

// File: tb/tb_qarma128_tweak_sched.sv
// Randomized bench for qarma128_tweak_sched against a cell-array reference model.
module tb_qarma128_tweak_sched;

  localparam int R = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_tweak;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_tweak;
  logic [3:0]   out_round;
  logic         out_dir;
  logic         out_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] obs [2*R];

  int h_tab [16]    = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};
  int lfsr_cells [7] = '{0, 1, 3, 4, 8, 11, 13};

  qarma128_tweak_sched #(.ROUNDS(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tweak  (in_tweak),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tweak (out_tweak),
    .out_round (out_round),
    .out_dir   (out_dir),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Forward round step T -> LFSR(h(T)) computed on a byte array.
  function automatic logic [127:0] ref_round(input logic [127:0] t);
    logic [7:0]   c [16];
    logic [7:0]   o [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) c[i] = t[127-8*i -: 8];
    for (int i = 0; i < 16; i++) o[i] = c[h_tab[i]];
    for (int k = 0; k < 7; k++) begin
      int n;
      n = lfsr_cells[k];
      o[n] = {o[n][0] ^ o[n][2], o[n][7:1]};
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!in_ready && n < 4*R) begin
      tick();
      n++;
    end
    check_eq("in_ready_wait", in_ready, 1'b1);
  endtask

  task automatic run_job(input logic [127:0] t, input int stall_at, input int rst_at,
                         input bit hold, input logic [127:0] t_next);
    logic [127:0] f [R];
    logic [127:0] exp_t;
    logic [3:0]   exp_r;
    int           k;
    f[0] = t;
    for (int j = 1; j < R; j++) f[j] = ref_round(f[j-1]);

    wait_ready();
    in_tweak = t;
    in_valid = 1'b1;
    tick();
    if (hold) in_tweak = t_next;
    else in_valid = 1'b0;

    for (int idx = 0; idx < 2*R; idx++) begin
      k     = (idx < R) ? idx : 2*R - 1 - idx;
      exp_t = f[k];
      exp_r = 4'(k);
      if (idx == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_ready", in_ready, 1'b1);
        check_eq("rst_tweak", out_tweak, '0);
        return;
      end
      check_eq("valid", out_valid, 1'b1);
      check_eq("busy", in_ready, 1'b0);
      check_eq("tweak", out_tweak, exp_t);
      check_eq("round", out_round, exp_r);
      check_eq("dir", out_dir, idx >= R);
      check_eq("last", out_last, idx == 2*R - 1);
      obs[idx] = out_tweak;
      if (idx == stall_at) begin
        out_ready = 1'b0;
        repeat (3) begin
          tick();
          check_eq("stall_valid", out_valid, 1'b1);
          check_eq("stall_tweak", out_tweak, exp_t);
          check_eq("stall_round", out_round, exp_r);
        end
        out_ready = 1'b1;
      end
      tick();
    end

    check_eq("final_eq_in", obs[2*R-1], t);
    check_eq("post_ready", in_ready, 1'b1);
    check_eq("post_valid", out_valid, 1'b0);
    if (hold) begin
      tick();
      in_valid = 1'b0;
      check_eq("reaccept_valid", out_valid, 1'b1);
      check_eq("reaccept_tweak", out_tweak, t_next);
      check_eq("reaccept_round", out_round, 4'd0);
      check_eq("reaccept_busy", in_ready, 1'b0);
      wait_ready();
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] exp_step;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_tweak  = '0;
    out_ready = 1'b1;
    repeat (2) tick();
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_tweak", out_tweak, '0);
    check_eq("rst_out_round", out_round, 4'd0);
    check_eq("rst_out_dir", out_dir, 1'b0);
    check_eq("rst_out_last", out_last, 1'b0);
    rst = 1'b0;
    tick();

    run_job('0, -1, -1, 1'b0, '0);

    run_job(128'h1 << 120, -1, -1, 1'b0, '0);
    exp_step = 128'h0000_0000_8000_0000_0000_0000_0000_0000;
    check_eq("cell4_step", obs[1], exp_step);

    run_job(rand128(), 3, -1, 1'b0, '0);
    run_job(rand128(), -1, 5, 1'b0, '0);
    run_job(rand128(), -1, -1, 1'b0, '0);
    run_job(rand128(), -1, -1, 1'b1, rand128());

    for (int j = 0; j < 6; j++) begin
      run_job(rand128(), int'($urandom_range(0, 2*R - 1)), -1, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
